// File: rtl/dmem_responder.sv
// Data-memory responder: latches one load/store request, waits WAIT_CYCLES, then accesses a word RAM.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [1:0]  byte_size,
  output logic [31:0] mem_data_out,
  output logic        mem_read_ready,
  output logic        mem_write_ready,
  output logic        misalign_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  logic [3:0]      count_q;
  logic            opWrite_q;
  logic [AW-1:0]   index_q;
  logic [1:0]      offset_q;
  logic [1:0]      size_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            rdReady_q;
  logic            wrReady_q;
  logic            err_q;

  logic [31:0]     mem_q [DEPTH];

  logic            isByte;
  logic            isHalf;
  logic            misaligned;
  logic            doWrite;
  logic [31:0]     ramWord;
  logic [31:0]     rdData_d;
  logic [31:0]     wrWord_d;
  logic            unusedAddrBits;

  // Address bits above the RAM index are deliberately ignored, so the RAM aliases.
  assign unusedAddrBits = ^mem_addr[31:AW+2];

  assign isByte  = (size_q == 2'd1);
  assign isHalf  = (size_q == 2'd2);
  assign ramWord = mem_q[index_q];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = isHalf ? offset_q[0] : (!isByte && (offset_q != 2'd0));
`else
  assign misaligned = 1'b0;
`endif

  // Lane merge for writes and low-aligned, zero-extended extraction for reads.
  always_comb begin
    rdData_d = ramWord;
    wrWord_d = ramWord;
    if (isByte) begin
      rdData_d = {24'd0, ramWord[{offset_q, 3'b000} +: 8]};
      wrWord_d[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (isHalf) begin
      rdData_d = {16'd0, ramWord[{offset_q[1], 4'b0000} +: 16]};
      wrWord_d[{offset_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      wrWord_d = wdata_q;
    end
    if (misaligned) begin
      rdData_d = '0;
    end
  end

  assign doWrite = (state_q == WAIT) && (count_q == 4'd0) && opWrite_q && !misaligned;

  // RAM has no reset; state_q is forced to IDLE asynchronously so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem_q[index_q] <= wrWord_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      opWrite_q <= 1'b0;
      index_q   <= '0;
      offset_q  <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rdReady_q <= 1'b0;
      wrReady_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_write_en || mem_read_en) begin
            opWrite_q <= mem_write_en;
            index_q   <= mem_addr[AW+1:2];
            offset_q  <= mem_addr[1:0];
            size_q    <= byte_size;
            wdata_q   <= mem_data;
            count_q   <= 4'(WAIT_CYCLES);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
          end else begin
            if (opWrite_q) begin
              wrReady_q <= 1'b1;
            end else begin
              rdReady_q <= 1'b1;
              rdata_q   <= rdData_d;
            end
            err_q   <= misaligned;
            state_q <= RESP;
          end
        end
        // Requests are never sampled here, so a still-held enable cannot retrigger.
        RESP: begin
          rdReady_q <= 1'b0;
          wrReady_q <= 1'b0;
          err_q     <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_data_out    = rdata_q;
  assign mem_read_ready  = rdReady_q;
  assign mem_write_ready = wrReady_q;
  assign misalign_err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboard of expected responses, two instances (WAIT_CYCLES 3 and 0).
// Misalign expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

  localparam int WAIT_MAIN = 3;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MISALIGN = 1'b1;
`else
  localparam bit MISALIGN = 1'b0;
`endif

  typedef struct packed {
    logic        rdRdy;
    logic        wrRdy;
    logic        err;
    logic [7:0]  lat;
    logic        oneCycle;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        err;
    logic [31:0] rv;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdEn, wrEn, sel;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [31:0] dataOutMain, dataOutZero;
  logic        rdRdyMain, wrRdyMain, errMain, rdRdyZero, wrRdyZero, errZero;
  logic [31:0] obsData;
  logic        obsRd, obsWr, obsErr;

  resp_t       expQ[$];
  logic [31:0] lastRead [2];
  int          testsRun = 0;
  int          failCount = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(WAIT_MAIN)) dutMain (
    .clk(clk), .rst(rst),
    .mem_read_en(rdEn & ~sel), .mem_write_en(wrEn & ~sel),
    .mem_addr(addr), .mem_data(wdata), .byte_size(size),
    .mem_data_out(dataOutMain), .mem_read_ready(rdRdyMain),
    .mem_write_ready(wrRdyMain), .misalign_err(errMain)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dutZero (
    .clk(clk), .rst(rst),
    .mem_read_en(rdEn & sel), .mem_write_en(wrEn & sel),
    .mem_addr(addr), .mem_data(wdata), .byte_size(size),
    .mem_data_out(dataOutZero), .mem_read_ready(rdRdyZero),
    .mem_write_ready(wrRdyZero), .misalign_err(errZero)
  );

  assign obsData = sel ? dataOutZero : dataOutMain;
  assign obsRd   = sel ? rdRdyZero   : rdRdyMain;
  assign obsWr   = sel ? wrRdyZero   : wrRdyMain;
  assign obsErr  = sel ? errZero     : errMain;

  // Model: response kind, latency and data the selected instance should produce.
  task automatic pushExp(input stim_t st);
    resp_t e;
    e.wrRdy    = st.wr;
    e.rdRdy    = !st.wr;
    e.err      = st.err;
    e.lat      = sel ? 8'd1 : 8'(WAIT_MAIN + 1);
    e.oneCycle = 1'b1;
    if (!st.wr) lastRead[sel] = st.rv;
    e.data     = lastRead[sel];
    expQ.push_back(e);
  endtask

  // Drives one request, holds the enable through the ready cycle and one edge beyond, records the response.
  task automatic applyStimulus(input stim_t st, output resp_t obs);
    bit found = 1'b0;
    bit ok1, ok2;
    pushExp(st);
    @(negedge clk);
    addr = st.a; wdata = st.d; size = st.s; rdEn = st.rd; wrEn = st.wr;
    @(posedge clk);
    obs = '0;
    obs.lat = 8'hFF;
    for (int e = 0; e < 20 && !found; e++) begin
      @(negedge clk);
      if (obsRd || obsWr) begin
        found = 1'b1;
        obs.lat = 8'(e); obs.rdRdy = obsRd; obs.wrRdy = obsWr;
        obs.err = obsErr; obs.data = obsData;
      end else begin
        @(posedge clk);
      end
    end
    if (found) begin
      @(posedge clk);
      @(negedge clk);
      ok1 = !(obsRd || obsWr || obsErr);
      rdEn = 1'b0; wrEn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ok2 = !(obsRd || obsWr);
      obs.oneCycle = ok1 && ok2;
    end else begin
      rdEn = 1'b0; wrEn = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; sel = 1'b0;
    addr = '0; wdata = '0; size = '0;
    lastRead[0] = '0; lastRead[1] = '0;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({dataOutMain, rdRdyMain, wrRdyMain, errMain} !== 35'd0) begin
      failCount++;
      $display("[TB] FAIL reset_main: got %h expected 0", {dataOutMain, rdRdyMain, wrRdyMain, errMain});
    end
    testsRun++;
    if ({dataOutZero, rdRdyZero, wrRdyZero, errZero} !== 35'd0) begin
      failCount++;
      $display("[TB] FAIL reset_zero: got %h expected 0", {dataOutZero, rdRdyZero, wrRdyZero, errZero});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_rw();
    stim_t tbl[$];
    resp_t obs, e;
    sel = 1'b0;
    tbl.push_back('{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h10, 32'h0,        2'd0, 1'b0, 32'hDEADBEEF});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], obs);
      e = expQ.pop_front();
      testsRun++;
      if (obs !== e) begin
        failCount++;
        $display("[TB] FAIL word_rw[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_byte_lanes();
    stim_t tbl[$];
    resp_t obs, e;
    sel = 1'b0;
    tbl.push_back('{1'b0, 1'b1, 32'h10,   32'h11223344, 2'd0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h13,   32'hFFFFFFA5, 2'd1, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h10,   32'h0,        2'd0, 1'b0, 32'hA5223344});
    tbl.push_back('{1'b1, 1'b0, 32'h13,   32'h0,        2'd1, 1'b0, 32'h000000A5});
    tbl.push_back('{1'b1, 1'b0, 32'h12,   32'h0,        2'd1, 1'b0, 32'h00000022});
    tbl.push_back('{1'b1, 1'b0, 32'h1010, 32'h0,        2'd0, 1'b0, 32'hA5223344});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], obs);
      e = expQ.pop_front();
      testsRun++;
      if (obs !== e) begin
        failCount++;
        $display("[TB] FAIL byte_lanes[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_half_lanes();
    stim_t tbl[$];
    resp_t obs, e;
    sel = 1'b0;
    tbl.push_back('{1'b0, 1'b1, 32'h20, 32'h0,        2'd0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h22, 32'hFFFFBEEF, 2'd2, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h22, 32'h0,        2'd2, 1'b0, 32'h0000BEEF});
    tbl.push_back('{1'b1, 1'b0, 32'h20, 32'h0,        2'd0, 1'b0, 32'hBEEF0000});
    tbl.push_back('{1'b1, 1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 32'h00000000});
    tbl.push_back('{1'b1, 1'b0, 32'h20, 32'h0,        2'd3, 1'b0, 32'hBEEF0000});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], obs);
      e = expQ.pop_front();
      testsRun++;
      if (obs !== e) begin
        failCount++;
        $display("[TB] FAIL half_lanes[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_wait0();
    stim_t tbl[$];
    resp_t obs, e;
    sel = 1'b1;
    tbl.push_back('{1'b0, 1'b1, 32'h8, 32'h0BADC0DE, 2'd0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h8, 32'h0,        2'd0, 1'b0, 32'h0BADC0DE});
    tbl.push_back('{1'b1, 1'b0, 32'h9, 32'h0,        2'd1, 1'b0, 32'h000000C0});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], obs);
      e = expQ.pop_front();
      testsRun++;
      if (obs !== e) begin
        failCount++;
        $display("[TB] FAIL wait0[%0d]: got %h expected %h", i, obs, e);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_both_en();
    stim_t tbl[$];
    resp_t obs, e;
    sel = 1'b0;
    tbl.push_back('{1'b1, 1'b1, 32'h40, 32'h00000055, 2'd0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h40, 32'h0,        2'd0, 1'b0, 32'h00000055});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], obs);
      e = expQ.pop_front();
      testsRun++;
      if (obs !== e) begin
        failCount++;
        $display("[TB] FAIL both_en[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_abort();
    stim_t st;
    resp_t obs, e;
    sel = 1'b0;
    st = '{1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 2'd0, 1'b0, 32'h0};
    applyStimulus(st, obs);
    e = expQ.pop_front();
    testsRun++;
    if (obs !== e) begin
      failCount++;
      $display("[TB] FAIL abort_setup: got %h expected %h", obs, e);
    end
    @(negedge clk);
    addr = 32'h44; wdata = 32'h12121212; size = 2'd0; wrEn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wrEn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    testsRun++;
    if ({dataOutMain, rdRdyMain, wrRdyMain, errMain} !== 35'd0) begin
      failCount++;
      $display("[TB] FAIL abort_outputs: got %h expected 0", {dataOutMain, rdRdyMain, wrRdyMain, errMain});
    end
    @(negedge clk);
    rst = 1'b0;
    lastRead[0] = '0; lastRead[1] = '0;
    st = '{1'b1, 1'b0, 32'h44, 32'h0, 2'd0, 1'b0, 32'hCAFEF00D};
    applyStimulus(st, obs);
    e = expQ.pop_front();
    testsRun++;
    if (obs !== e) begin
      failCount++;
      $display("[TB] FAIL abort_ram_kept: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_misalign();
    stim_t tbl[$];
    resp_t obs, e;
    sel = 1'b0;
    tbl.push_back('{1'b0, 1'b1, 32'h41, 32'h12345678, 2'd0, MISALIGN, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h40, 32'h0, 2'd0, 1'b0, MISALIGN ? 32'h00000055 : 32'h12345678});
    tbl.push_back('{1'b1, 1'b0, 32'h42, 32'h0, 2'd0, MISALIGN, MISALIGN ? 32'h0 : 32'h12345678});
    tbl.push_back('{1'b1, 1'b0, 32'h43, 32'h0, 2'd2, MISALIGN, MISALIGN ? 32'h0 : 32'h00001234});
    tbl.push_back('{1'b1, 1'b0, 32'h41, 32'h0, 2'd1, 1'b0, MISALIGN ? 32'h0 : 32'h00000056});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], obs);
      e = expQ.pop_front();
      testsRun++;
      if (obs !== e) begin
        failCount++;
        $display("[TB] FAIL misalign[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_half_lanes();
    test_wait0();
    test_both_en();
    test_reset_abort();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
